// File: rtl/uart_sram_bridge.sv
// UART byte-stream to single-port SRAM command bridge.
// Supports ping, burst write with ack, burst read, bad-opcode reply and rx timeout.
module uart_sram_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              csb_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              busy,
  output logic              err
);

  localparam int BYTES = DATA_W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int LCW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [BCW-1:0] BLAST = BCW'(BYTES - 1);
  localparam logic [LCW-1:0] LLAST = LCW'(RD_LAT - 1);
  localparam logic [23:0]    TLAST = (TIMEOUT > 0) ? 24'(TIMEOUT - 1) : 24'd0;
  localparam bit             TEN   = (TIMEOUT > 0);

  localparam logic [7:0] OP_W   = 8'h57;
  localparam logic [7:0] OP_R   = 8'h52;
  localparam logic [7:0] OP_P   = 8'h50;
  localparam logic [7:0] RP_ACK = 8'h4B;
  localparam logic [7:0] RP_PNG = 8'hA5;
  localparam logic [7:0] RP_BAD = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_WSTB,
    S_RSTB,
    S_RWAIT,
    S_RSEND,
    S_ACK,
    S_PING,
    S_BADOP
  } state_t;

  state_t            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [LCW-1:0]    lcnt_q, lcnt_d;
  logic [23:0]       tcnt_q, tcnt_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [7:0]        txd_q, txd_d;
  logic              txv_q, txv_d;
  logic              rxr_q, rxr_d;
  logic              csb_q, csb_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              rx_fire;
  logic              tx_fire;
  logic              in_rx;
  logic              tmo;
  logic [DATA_W-1:0] wword;
  logic [DATA_W-1:0] rnext;

  assign rx_ready = rxr_q;
  assign tx_data  = txd_q;
  assign tx_valid = txv_q;
  assign csb_n    = csb_q;
  assign we_n     = we_q;
  assign addr     = addr_q;
  assign sram_din = din_q;
  assign busy     = busy_q;
  assign err      = err_q;

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    lcnt_d  = lcnt_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    din_d   = din_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    csb_d   = csb_q;
    we_d    = we_q;
    err_d   = 1'b0;

    rx_fire = rx_valid & rxr_q;
    tx_fire = txv_q & tx_ready;
    in_rx   = (state_q == S_ADDR) ||
              (state_q == S_LEN) ||
              (state_q == S_WDATA);
    tmo     = TEN && in_rx && (tcnt_q == TLAST);
    tcnt_d  = (rx_fire || !in_rx || !TEN) ?
              24'd0 : tcnt_q + 24'd1;

    // Words arrive LSB-first: shift right, new byte enters at the top.
    wword = (wbuf_q >> 8) |
            (DATA_W'(rx_data) << (DATA_W - 8));
    rnext = rbuf_q >> 8;

    if (tmo) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Opcode is decoded on the accepting edge.
          if (rx_fire) begin
            unique case (1'b1)
              (rx_data == OP_W): begin
                is_wr_d = 1'b1;
                state_d = S_ADDR;
              end
              (rx_data == OP_R): begin
                is_wr_d = 1'b0;
                state_d = S_ADDR;
              end
              (rx_data == OP_P): begin
                txd_d   = RP_PNG;
                txv_d   = 1'b1;
                state_d = S_PING;
              end
              default: begin
                txd_d   = RP_BAD;
                txv_d   = 1'b1;
                err_d   = 1'b1;
                state_d = S_BADOP;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr_d  = rx_data[ADDR_W-1:0];
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (rx_fire) begin
            len_d  = rx_data;
            bcnt_d = '0;
            if (is_wr_q) begin
              state_d = S_WDATA;
            end else begin
              csb_d   = 1'b0;
              state_d = S_RSTB;
            end
          end
        end
        S_WDATA: begin
          if (rx_fire) begin
            wbuf_d = wword;
            if (bcnt_q == BLAST) begin
              bcnt_d  = '0;
              din_d   = wword;
              csb_d   = 1'b0;
              we_d    = 1'b0;
              state_d = S_WSTB;
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
            end
          end
        end
        S_WSTB: begin
          csb_d  = 1'b1;
          we_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (len_q == 8'd0) begin
            txd_d   = RP_ACK;
            txv_d   = 1'b1;
            state_d = S_ACK;
          end else begin
            len_d   = len_q - 8'd1;
            state_d = S_WDATA;
          end
        end
        S_RSTB: begin
          csb_d   = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          lcnt_d  = '0;
          state_d = S_RWAIT;
        end
        S_RWAIT: begin
          if (lcnt_q == LLAST) begin
            rbuf_d  = sram_dout;
            txd_d   = sram_dout[7:0];
            txv_d   = 1'b1;
            bcnt_d  = '0;
            state_d = S_RSEND;
          end else begin
            lcnt_d = lcnt_q + LCW'(1);
          end
        end
        S_RSEND: begin
          if (tx_fire) begin
            if (bcnt_q == BLAST) begin
              txv_d  = 1'b0;
              bcnt_d = '0;
              if (len_q == 8'd0) begin
                state_d = S_IDLE;
              end else begin
                len_d   = len_q - 8'd1;
                csb_d   = 1'b0;
                state_d = S_RSTB;
              end
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
              rbuf_d = rnext;
              txd_d  = rnext[7:0];
            end
          end
        end
        S_ACK, S_PING, S_BADOP: begin
          if (tx_fire) begin
            txv_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    rxr_d  = (state_d == S_IDLE) ||
             (state_d == S_ADDR) ||
             (state_d == S_LEN) ||
             (state_d == S_WDATA);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      bcnt_q  <= '0;
      lcnt_q  <= '0;
      tcnt_q  <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
      din_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      rxr_q   <= 1'b0;
      csb_q   <= 1'b1;
      we_q    <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      lcnt_q  <= lcnt_d;
      tcnt_q  <= tcnt_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      din_q   <= din_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      rxr_q   <= rxr_d;
      csb_q   <= csb_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/uart_sram_bridge.md
# uart_sram_bridge

Parametrised UART-to-SRAM command bridge: the next generation of the tile's SRAM controller. It sits between the UART receiver/transmitter byte streams and a single-port, OpenRAM-style synchronous SRAM macro. It decodes a byte-oriented command protocol with burst reads and writes of configurable word width and depth, auto-incrementing addresses, write acknowledge, opcode error reporting and an inter-byte timeout.

## Interface
- DATA_W, 32, SRAM word width in bits; multiple of 8, 8..64; BYTES = DATA_W/8
- ADDR_W, 5, SRAM address width, 1..8
- RD_LAT, 1, cycles from read strobe to valid sram_dout, 1..3
- TIMEOUT, 0, max idle cycles between rx bytes inside a command; 0 disables, otherwise 1..2^24-1

- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid; byte consumed when rx_valid & rx_ready
- rx_ready  out  1  bridge can accept a byte
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held with tx_data stable until tx_valid & tx_ready
- tx_ready  in  1  transmitter accepts byte
- csb_n  out  1  SRAM chip select, active low
- we_n  out  1  SRAM write enable, active low
- addr  out  ADDR_W  SRAM address
- sram_din  out  DATA_W  SRAM write data
- sram_dout  in  DATA_W  SRAM read data
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle pulse on bad opcode or timeout

## Operation
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, csb_n=1, we_n=1, addr=0, sram_din=0, busy=0, err=0; state=IDLE.
- Frame format: OP, ADDR, LEN[, data]. The word count is LEN+1 (1..256). The start address is ADDR[ADDR_W-1:0]; upper bits are ignored.
- OP 0x57 'W', write:
  - The host sends (LEN+1)*BYTES data bytes, each word LSB-first.
  - After each full word, one SRAM write cycle is issued.
  - After the last word, the bridge sends 0x4B 'K'.
- OP 0x52 'R', read: for each word, one SRAM read is issued and the word is returned as BYTES bytes, LSB-first.
- OP 0x50 'P', ping: no ADDR/LEN bytes follow. The bridge replies 0xA5.
- Any other OP: err pulses and the bridge replies 0xEE. The following bytes are treated as new opcodes.
- Address increments after every word and wraps modulo 2^ADDR_W (e.g. ADDR_W=5: 31 -> 0).
- States:
  - IDLE -> OPC: on first byte, same cycle.
  - OPC -> ADDR (W/R), PING, or BADOP.
  - ADDR -> LEN.
  - LEN -> WDATA (W) or RSTB (R).
  - WDATA -> WSTB: after BYTES bytes.
  - WSTB -> WDATA, or ACK after the last word.
  - RSTB -> RWAIT.
  - RWAIT -> RSEND: after RD_LAT cycles.
  - RSEND -> RSTB, or IDLE after the last byte of the last word.
  - ACK, PING, BADOP -> IDLE: once the reply byte is accepted.
- rx_ready is high only in IDLE, ADDR, LEN and WDATA. Bytes arriving elsewhere are held off by the transmitter-side flow control, never dropped by the bridge.
- Timeout (TIMEOUT>0):
  - A counter clears on every accepted rx byte and counts in ADDR, LEN and WDATA.
  - When it reaches TIMEOUT, err pulses for one cycle, the partial word is discarded (no SRAM write), and the state returns to IDLE. No reply byte is sent.
  - Words already written in the burst stay written.

## Timing
- Write strobe:
  - The cycle after the last byte of a word is accepted, the bridge drives csb_n=0, we_n=0, addr and sram_din for exactly one cycle.
  - The following cycle returns to csb_n=1, we_n=1.
- Read strobe: csb_n=0, we_n=1 for one cycle. sram_dout is captured into the shift register exactly RD_LAT cycles after the strobe cycle.
- The first tx byte of a read word is asserted the cycle after capture. Each next byte is asserted the cycle after the previous tx handshake.
- Reply latency: 'K'/0xA5/0xEE tx_valid rises the cycle after the triggering byte or write strobe.
- A back-to-back word write costs BYTES rx bytes + 1 strobe cycle. At most one SRAM access is active per cycle.
- tx_valid must never drop or change data before handshake; tx_ready stalls of any length are tolerated.
- Reset asserted mid-operation: all outputs return to reset values on the next edge. An in-flight SRAM strobe is not completed and no reply is sent.
- err and rx handshake in the same cycle as timeout expiry: the timeout wins and the byte is dropped.

## Test plan
- Ping: rx 0x50 -> tx 0xA5 exactly once, busy high until handshake, no SRAM strobe.
- Single write + read (DATA_W=32):
  - W: rx 0x57,0x03,0x00,0x78,0x56,0x34,0x12 -> one strobe with addr=3, sram_din=0x12345678, then tx 0x4B.
  - R: rx 0x52,0x03,0x00 -> tx 0x78,0x56,0x34,0x12.
- Wrap burst (ADDR_W=5): write LEN=2 at ADDR=30 -> strobes at 30, 31, 0. Read back returns 3 matching words in order.
- Bad opcode: rx 0x13 -> err one-cycle pulse, tx 0xEE. A following 0x50 still yields 0xA5.
- Timeout (TIMEOUT=100): rx 0x57,0x01,0x00,0xAA then silence -> err pulse 100 cycles after 0xAA, no SRAM write, state IDLE.
- Backpressure and reset: read LEN=1 with tx_ready random 30% -> tx_data stable while tx_valid & !tx_ready, 8 bytes correct. Assert reset mid-burst -> all outputs at reset values next cycle.
